aes_key_expand: RTL and testbench
=================================

Name: aes_key_expand

Overview:
AES-128 key-schedule producer for the encryption datapath. It pops one 128-bit cipher key from an input FIFO and pushes the NUM_ROUNDS+1 round keys (round 0 through round 10) into the round-key FIFO. The add-round-key stage reads that FIFO through its rd/empty interface. This block is the writer side of that interface and uses the same FIFO-style handshake: rd/empty on the input, wr/full on the output.

Parameters:
NUM_ROUNDS, 10, index of the last round key. The block emits NUM_ROUNDS+1 keys per cipher key. The rcon table supports values up to 10.

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset
cipher_key  input  128  head of the cipher-key FIFO
cipher_key_rd  output  1  pop strobe for the cipher-key FIFO
cipher_key_empty  input  1  cipher-key FIFO empty
round_key  output  128  round key presented to the round-key FIFO
round_key_wr  output  1  push strobe for the round-key FIFO
round_key_full  input  1  round-key FIFO full

Behaviour:
- Byte order: byte i occupies bits [8i+7:8i]. Word j is bytes 4j..4j+3, with byte 4j first.
- State: FSM {IDLE, EMIT}, plus:
  - key_reg[127:0]
  - rnd counter, 4 bits
  - rcon[7:0]
- Reset (reset=0, async):
  - FSM=IDLE, key_reg=0, rnd=0, rcon=8'h01.
  - cipher_key_rd=0, round_key_wr=0, round_key=0.
- IDLE:
  - cipher_key_rd = !cipher_key_empty (combinational).
  - On a pop: key_reg<=cipher_key, rnd<=0, rcon<=8'h01, go to EMIT.
- EMIT:
  - round_key = key_reg (registered, so round key 0 is written the cycle after the pop).
  - round_key_wr = !round_key_full (combinational). cipher_key_rd=0.
- On each EMIT write:
  - If rnd==NUM_ROUNDS: return to IDLE. A new cipher key may be popped on the next cycle, so the gap is 1 cycle.
  - Otherwise: key_reg<=next_key, rnd<=rnd+1, rcon<=xtime(rcon).
- xtime(x) = (x<<1) ^ (x[7] ? 8'h1B : 0). Sequence: 01,02,04,08,10,20,40,80,1B,36.
- next_key:
  - t = SubWord(RotWord(w3)) ^ {rcon on byte 0 only}.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - RotWord maps (b0,b1,b2,b3) to (b1,b2,b3,b0).
  - SubWord applies the FIPS-197 S-box to each byte; the S-box is a combinational lookup.
- Throughput: one round key per cycle while the output FIFO is not full.
- round_key_full stall: round_key_wr=0 and all state holds. round_key keeps its value, and there is no limit on stall length.
- round_key is held stable in IDLE (last value); it is meaningful only when round_key_wr=1.
- Reset mid-operation: the sequence is abandoned, no further writes occur, and the partially consumed key is lost.

Optional Feature:
AES_KEYEXP_REVERSE_EN — decryption ordering.
- Defined:
  - Adds a 16-entry x 128-bit key buffer and a GEN state between IDLE and EMIT.
  - GEN computes all NUM_ROUNDS+1 keys into the buffer at one per cycle, writing no output.
  - EMIT then writes buffer entries NUM_ROUNDS down to 0.
  - Latency from pop to first write is NUM_ROUNDS+2 cycles.
  - Stalls on round_key_full hold the read index.
  - The buffer is not cleared on reset.
- Undefined:
  - The buffer and GEN state are absent.
  - Forward order as specified above.

Test Plan:
1. FIPS-197 key bytes 2b 7e 15 16 28 ae d2 a6 ab f7 15 88 09 cf 4f 3c, round_key_full=0 -> 11 consecutive writes:
   - write 0 equals the key.
   - write 1 = a0 fa fe 17 88 54 2c b1 23 a3 39 39 2a 6c 76 05.
   - write 10 = d0 14 f9 a8 c9 ee 25 89 e1 3f 0c c8 b6 63 0c a6.
   - cipher_key_rd is pulsed exactly once.
2. Same key, round_key_full held high for 5 cycles after write 3 -> no writes during the stall, write 4 follows with the unchanged value, 11 writes total.
3. Two keys queued back-to-back (test 1 key, then all-zero key) -> second pop occurs 1 cycle after write 10 of the first key. Zero key round 1 = 62 63 63 63 62 63 63 63 62 63 63 63 62 63 63 63.
4. cipher_key_empty=1 for 20 cycles -> cipher_key_rd=0, round_key_wr=0, FSM remains IDLE.
5. Assert reset low after write 5 for 1 cycle, then supply the test 1 key again -> outputs clear immediately on reset. The next sequence restarts from round 0 with correct rcon (write 1 equals test 1 value).
6. AES_KEYEXP_REVERSE_EN defined, test 1 key -> first write occurs 12 cycles after the pop and equals round 10 (d0 14 f9 a8 ...); the last write equals the cipher key.

Source files
------------

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: pops one cipher key, pushes NUM_ROUNDS+1 round keys (FIFO rd/empty in, wr/full out).
// Optional macro AES_KEYEXP_REVERSE_EN: buffer the whole schedule in a GEN state and emit it last round first.
module aes_key_expand #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [127:0] cipher_key,
    output logic         cipher_key_rd,
    input  logic         cipher_key_empty,
    output logic [127:0] round_key,
    output logic         round_key_wr,
    input  logic         round_key_full,
    output logic [1:0]   dbg_state
);
    // Handshake: a transfer happens on any rising edge where cipher_key_rd (pop) or round_key_wr (push)
    // is high; both strobes are combinational from the current state and the empty/full flag.
    typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1, GEN = 2'd2} state_t;

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

    // FIPS-197 S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_FLAT[{~b, 3'b000} +: 8];
    endfunction

    state_t       state_q, state_d;
    logic [127:0] key_reg_q, key_reg_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         started_q;
    logic [31:0]  w0, w1, w2, w3, rot_w, t_w, n0, n1, n2, n3;
    logic [127:0] next_key;
    logic [7:0]   rcon_next;

`ifdef AES_KEYEXP_REVERSE_EN
    logic [127:0] key_buf [16];
    logic         buf_we;
    logic [3:0]   rd_idx_q, rd_idx_d;
    logic [127:0] round_key_q, round_key_d;
`endif

    always_comb begin
        w0        = key_reg_q[31:0];
        w1        = key_reg_q[63:32];
        w2        = key_reg_q[95:64];
        w3        = key_reg_q[127:96];
        // Byte 0 sits in the low bits of a word, so RotWord is a right rotate by one byte.
        rot_w     = {w3[7:0], w3[31:8]};
        t_w       = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])}
                    ^ {24'h000000, rcon_q};
        n0        = w0 ^ t_w;
        n1        = w1 ^ n0;
        n2        = w2 ^ n1;
        n3        = w3 ^ n2;
        next_key  = {n3, n2, n1, n0};
        rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    end

    always_comb begin
        state_d       = state_q;
        key_reg_d     = key_reg_q;
        rnd_d         = rnd_q;
        rcon_d        = rcon_q;
        cipher_key_rd = 1'b0;
        round_key_wr  = 1'b0;
`ifdef AES_KEYEXP_REVERSE_EN
        buf_we        = 1'b0;
        rd_idx_d      = rd_idx_q;
        round_key_d   = round_key_q;
`endif
        case (state_q)
            IDLE: begin
                // started_q keeps the pop strobe low while reset is held.
                cipher_key_rd = started_q & ~cipher_key_empty;
                if (cipher_key_rd) begin
                    key_reg_d = cipher_key;
                    rnd_d     = 4'd0;
                    rcon_d    = 8'h01;
`ifdef AES_KEYEXP_REVERSE_EN
                    state_d   = GEN;
`else
                    state_d   = EMIT;
`endif
                end
            end
`ifdef AES_KEYEXP_REVERSE_EN
            GEN: begin
                buf_we = 1'b1;
                if (rnd_q == LAST_RND) begin
                    state_d     = EMIT;
                    rd_idx_d    = LAST_RND;
                    round_key_d = key_reg_q;
                end else begin
                    key_reg_d = next_key;
                    rnd_d     = rnd_q + 4'd1;
                    rcon_d    = rcon_next;
                end
            end
            EMIT: begin
                round_key_wr = ~round_key_full;
                if (round_key_wr) begin
                    if (rd_idx_q == 4'd0) begin
                        state_d = IDLE;
                    end else begin
                        rd_idx_d    = rd_idx_q - 4'd1;
                        round_key_d = key_buf[rd_idx_q - 4'd1];
                    end
                end
            end
`else
            EMIT: begin
                round_key_wr = ~round_key_full;
                if (round_key_wr) begin
                    if (rnd_q == LAST_RND) begin
                        state_d = IDLE;
                    end else begin
                        key_reg_d = next_key;
                        rnd_d     = rnd_q + 4'd1;
                        rcon_d    = rcon_next;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            key_reg_q   <= '0;
            rnd_q       <= '0;
            rcon_q      <= 8'h01;
            started_q   <= 1'b0;
`ifdef AES_KEYEXP_REVERSE_EN
            rd_idx_q    <= '0;
            round_key_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            key_reg_q   <= key_reg_d;
            rnd_q       <= rnd_d;
            rcon_q      <= rcon_d;
            started_q   <= 1'b1;
`ifdef AES_KEYEXP_REVERSE_EN
            rd_idx_q    <= rd_idx_d;
            round_key_q <= round_key_d;
`endif
        end
    end

`ifdef AES_KEYEXP_REVERSE_EN
    // Buffer contents survive reset; every entry is rewritten in GEN before it is read.
    always_ff @(posedge clock) begin
        if (buf_we) begin
            key_buf[rnd_q] <= key_reg_q;
        end
    end

    assign round_key = round_key_q;
`else
    assign round_key = key_reg_q;
`endif

    assign dbg_state = state_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: FIFO models on both sides, GF(2^8)-derived S-box reference schedule.
// Honours AES_KEYEXP_REVERSE_EN for the expected write order and pop-to-first-write latency.
module tb_aes_key_expand;
    localparam int NR = 10;
    localparam int NK = NR + 1;
    localparam logic [1:0] ST_IDLE = 2'd0;
`ifdef AES_KEYEXP_REVERSE_EN
    localparam bit REVERSE = 1'b1;
    localparam int LAT = NR + 2;
`else
    localparam bit REVERSE = 1'b0;
    localparam int LAT = 1;
`endif

    logic         clock;
    logic         reset = 1'b0;
    logic [127:0] cipher_key = '0;
    logic         cipher_key_rd;
    logic         cipher_key_empty = 1'b1;
    logic [127:0] round_key;
    logic         round_key_wr;
    logic         round_key_full = 1'b0;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int full_viol = 0;
    logic rd_seen = 1'b0;

    logic [127:0] key_fifo[$];
    logic [127:0] exp_q[$];
    logic [127:0] got_q[$];
    int           got_cyc[$];
    int           pop_cyc[$];
    logic [7:0]   sbox_tab[256];
    logic [127:0] model_rk[NK];

    aes_key_expand #(.NUM_ROUNDS(NR)) dut (
        .clock(clock), .reset(reset),
        .cipher_key(cipher_key), .cipher_key_rd(cipher_key_rd), .cipher_key_empty(cipher_key_empty),
        .round_key(round_key), .round_key_wr(round_key_wr), .round_key_full(round_key_full),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Monitor: samples strobes mid-cycle, logs writes and pops.
    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            rd_seen = cipher_key_rd;
            if (round_key_wr) begin
                got_q.push_back(round_key);
                got_cyc.push_back(cyc);
                if (round_key_full) full_viol++;
            end
            if (cipher_key_rd) pop_cyc.push_back(cyc);
        end
    end

    // Cipher-key FIFO model: pops after an edge that saw the read strobe.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (rd_seen && key_fifo.size() > 0) void'(key_fifo.pop_front());
            cipher_key_empty = (key_fifo.size() == 0);
            cipher_key       = (key_fifo.size() > 0) ? key_fifo[0] : '0;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [127:0] be2v(input logic [127:0] be);
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[8*i +: 8] = be[8*(15-i) +: 8];
        return v;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    task automatic init_sbox();
        logic [7:0] inv;
        for (int b = 0; b < 256; b++) begin
            inv = 8'h00;
            for (int c = 1; c < 256; c++) if (gmul(8'(b), 8'(c)) == 8'h01) inv = 8'(c);
            sbox_tab[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_expand(input logic [127:0] key);
        logic [7:0] w[4*NK][4];
        logic [7:0] t[4];
        logic [7:0] rc;
        for (int i = 0; i < 4; i++) for (int b = 0; b < 4; b++) w[i][b] = key[8*(4*i+b) +: 8];
        rc = 8'h01;
        for (int i = 4; i < 4*NK; i++) begin
            for (int b = 0; b < 4; b++)
                t[b] = (i % 4 == 0) ? sbox_tab[w[i-1][(b+1)%4]] : w[i-1][b];
            if (i % 4 == 0) begin
                t[0] = t[0] ^ rc;
                rc   = gmul(rc, 8'h02);
            end
            for (int b = 0; b < 4; b++) w[i][b] = w[i-4][b] ^ t[b];
        end
        for (int r = 0; r < NK; r++)
            for (int j = 0; j < 4; j++)
                for (int b = 0; b < 4; b++) model_rk[r][8*(4*j+b) +: 8] = w[4*r+j][b];
    endtask

    function automatic int pos(input int r);
        return REVERSE ? NR - r : r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic push_expected();
        for (int r = 0; r < NK; r++) exp_q.push_back(model_rk[pos(r)]);
    endtask

    task automatic clear_logs();
        got_q.delete();
        got_cyc.delete();
        pop_cyc.delete();
        exp_q.delete();
    endtask

    task automatic wait_writes(input int n, input int budget);
        for (int c = 0; c < budget && got_q.size() < n; c++) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        key_fifo.push_back(be2v(128'h2b7e151628aed2a6abf7158809cf4f3c));
        idle_cycles(3);
        n_checks++;
        if (round_key !== 128'h0) begin n_fail++; $display("FAIL reset_round_key: got %h want 0", round_key); end
        n_checks++;
        if (round_key_wr !== 1'b0) begin n_fail++; $display("FAIL reset_wr: got %b want 0", round_key_wr); end
        n_checks++;
        if (cipher_key_rd !== 1'b0) begin n_fail++; $display("FAIL reset_rd: got %b want 0 (fifo not empty)", cipher_key_rd); end
        n_checks++;
        if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
        key_fifo.delete();
        idle_cycles(1);
        reset = 1'b1;
        idle_cycles(2);
        n_checks++;
        if (got_q.size() !== 0) begin n_fail++; $display("FAIL reset_no_writes: got %0d writes want 0", got_q.size()); end
    endtask

    task automatic test_fips();
        logic [127:0] k;
        k = be2v(128'h2b7e151628aed2a6abf7158809cf4f3c);
        clear_logs();
        model_expand(k);
        push_expected();
        key_fifo.push_back(k);
        wait_writes(NK, 200);
        idle_cycles(4);
        n_checks++;
        if (got_q.size() !== NK) begin n_fail++; $display("FAIL fips_count: got %0d writes want %0d", got_q.size(), NK); end
        n_checks++;
        if (pop_cyc.size() !== 1) begin n_fail++; $display("FAIL fips_pops: got %0d pops want 1", pop_cyc.size()); end
        n_checks++;
        if (got_cyc[0] - pop_cyc[0] !== LAT) begin
            n_fail++; $display("FAIL fips_latency: got %0d cycles want %0d", got_cyc[0] - pop_cyc[0], LAT);
        end
        for (int i = 0; i < NK; i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL fips_write%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        for (int i = 1; i < NK; i++) begin
            n_checks++;
            if (got_cyc[i] - got_cyc[i-1] !== 1) begin
                n_fail++; $display("FAIL fips_gap%0d: got %0d cycles want 1", i, got_cyc[i] - got_cyc[i-1]);
            end
        end
        n_checks++;
        if (got_q[pos(0)] !== k) begin n_fail++; $display("FAIL fips_round0: got %h want %h", got_q[pos(0)], k); end
        n_checks++;
        if (got_q[pos(1)] !== be2v(128'ha0fafe1788542cb123a339392a6c7605)) begin
            n_fail++; $display("FAIL fips_round1: got %h want %h", got_q[pos(1)], be2v(128'ha0fafe1788542cb123a339392a6c7605));
        end
        n_checks++;
        if (got_q[pos(NR)] !== be2v(128'hd014f9a8c9ee2589e13f0cc8b6630ca6)) begin
            n_fail++; $display("FAIL fips_round10: got %h want %h", got_q[pos(NR)], be2v(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
        end
    endtask

    task automatic test_stall();
        logic [127:0] k;
        k = be2v(128'h2b7e151628aed2a6abf7158809cf4f3c);
        clear_logs();
        model_expand(k);
        push_expected();
        key_fifo.push_back(k);
        wait_writes(4, 100);
        round_key_full = 1'b1;
        idle_cycles(4);
        n_checks++;
        if (round_key_wr !== 1'b0) begin n_fail++; $display("FAIL stall_wr: got %b want 0", round_key_wr); end
        n_checks++;
        if (round_key !== exp_q[4]) begin n_fail++; $display("FAIL stall_hold: got %h want %h", round_key, exp_q[4]); end
        idle_cycles(1);
        round_key_full = 1'b0;
        wait_writes(NK, 100);
        idle_cycles(4);
        n_checks++;
        if (got_q.size() !== NK) begin n_fail++; $display("FAIL stall_count: got %0d writes want %0d", got_q.size(), NK); end
        n_checks++;
        if (got_cyc[4] - got_cyc[3] !== 6) begin
            n_fail++; $display("FAIL stall_gap: got %0d cycles want 6", got_cyc[4] - got_cyc[3]);
        end
        for (int i = 0; i < NK; i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_write%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] k;
        k = be2v(128'h2b7e151628aed2a6abf7158809cf4f3c);
        clear_logs();
        model_expand(k);
        push_expected();
        model_expand(128'h0);
        push_expected();
        key_fifo.push_back(k);
        key_fifo.push_back(128'h0);
        wait_writes(2*NK, 300);
        idle_cycles(4);
        n_checks++;
        if (got_q.size() !== 2*NK) begin n_fail++; $display("FAIL b2b_count: got %0d writes want %0d", got_q.size(), 2*NK); end
        n_checks++;
        if (pop_cyc.size() !== 2) begin n_fail++; $display("FAIL b2b_pops: got %0d pops want 2", pop_cyc.size()); end
        n_checks++;
        if (pop_cyc[1] - got_cyc[NK-1] !== 1) begin
            n_fail++; $display("FAIL b2b_pop_gap: got %0d cycles want 1", pop_cyc[1] - got_cyc[NK-1]);
        end
        for (int i = 0; i < 2*NK; i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_write%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_checks++;
        if (got_q[NK + pos(1)] !== be2v(128'h62636363626363636263636362636363)) begin
            n_fail++; $display("FAIL b2b_zero_round1: got %h want %h", got_q[NK + pos(1)],
                               be2v(128'h62636363626363636263636362636363));
        end
    endtask

    task automatic test_idle();
        clear_logs();
        for (int c = 0; c < 20; c++) begin
            idle_cycles(1);
            n_checks++;
            if (cipher_key_rd !== 1'b0) begin n_fail++; $display("FAIL idle_rd c%0d: got %b want 0", c, cipher_key_rd); end
            n_checks++;
            if (round_key_wr !== 1'b0) begin n_fail++; $display("FAIL idle_wr c%0d: got %b want 0", c, round_key_wr); end
            n_checks++;
            if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL idle_state c%0d: got %0d want %0d", c, dbg_state, ST_IDLE); end
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] k;
        int n;
        k = be2v(128'h2b7e151628aed2a6abf7158809cf4f3c);
        clear_logs();
        key_fifo.push_back(k);
        wait_writes(6, 100);
        reset = 1'b0;
        #1;
        n_checks++;
        if (round_key_wr !== 1'b0) begin n_fail++; $display("FAIL rstmid_wr: got %b want 0", round_key_wr); end
        n_checks++;
        if (round_key !== 128'h0) begin n_fail++; $display("FAIL rstmid_round_key: got %h want 0", round_key); end
        n_checks++;
        if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL rstmid_state: got %0d want %0d", dbg_state, ST_IDLE); end
        idle_cycles(1);
        reset = 1'b1;
        n = got_q.size();
        idle_cycles(5);
        n_checks++;
        if (got_q.size() !== n) begin n_fail++; $display("FAIL rstmid_abandon: got %0d writes want %0d", got_q.size(), n); end
        clear_logs();
        model_expand(k);
        push_expected();
        key_fifo.push_back(k);
        wait_writes(NK, 200);
        idle_cycles(4);
        n_checks++;
        if (got_q.size() !== NK) begin n_fail++; $display("FAIL rstmid_count: got %0d writes want %0d", got_q.size(), NK); end
        for (int i = 0; i < NK; i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rstmid_write%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_checks++;
        if (got_q[pos(1)] !== be2v(128'ha0fafe1788542cb123a339392a6c7605)) begin
            n_fail++; $display("FAIL rstmid_round1: got %h want %h", got_q[pos(1)], be2v(128'ha0fafe1788542cb123a339392a6c7605));
        end
    endtask

    task automatic test_random();
        logic [127:0] k;
        clear_logs();
        for (int j = 0; j < 4; j++) begin
            k = {$urandom(), $urandom(), $urandom(), $urandom()};
            model_expand(k);
            push_expected();
            key_fifo.push_back(k);
        end
        for (int c = 0; c < 2000 && got_q.size() < 4*NK; c++) begin
            @(posedge clock);
            #2;
            round_key_full = ($urandom_range(0, 3) == 0);
        end
        round_key_full = 1'b0;
        idle_cycles(4);
        n_checks++;
        if (got_q.size() !== 4*NK) begin n_fail++; $display("FAIL rand_count: got %0d writes want %0d", got_q.size(), 4*NK); end
        n_checks++;
        if (pop_cyc.size() !== 4) begin n_fail++; $display("FAIL rand_pops: got %0d pops want 4", pop_cyc.size()); end
        n_checks++;
        if (full_viol !== 0) begin n_fail++; $display("FAIL rand_write_while_full: got %0d want 0", full_viol); end
        for (int i = 0; i < 4*NK; i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_write%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        init_sbox();
        test_reset();
        test_fips();
        test_stall();
        test_back_to_back();
        test_idle();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
